// File: rtl/fpu_job_issuer.sv
// Initiator side of the FPU en/fi handshake: latches an operand set, pulses fpu_en,
// waits for fpu_fi (or a watchdog abort) and offers the captured result downstream.
module fpu_job_issuer #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_vld,
  output logic             job_rdy,
  input  logic [DW-1:0]    job_a,
  input  logic [DW-1:0]    job_b,
  input  logic [DW-1:0]    job_c,
  input  logic [DW-1:0]    job_d,
  output logic             fpu_en,
  input  logic             fpu_fi,
  output logic [DW-1:0]    fpu_a,
  output logic [DW-1:0]    fpu_b,
  output logic [DW-1:0]    fpu_c,
  output logic [DW-1:0]    fpu_d,
  input  logic [DW-1:0]    fpu_g,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [DW-1:0]    res_g,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] job_cnt,
  output logic [1:0]       state_dbg
);

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; valid-side data is held stable until that edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] wd;
  logic            wd_expired;

  assign wd_expired = (wd == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (fpu_fi || wd_expired) state_nxt = RESP;
      RESP:    if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    job_rdy   = (state == IDLE);
    fpu_en    = (state == ISSUE);
    res_vld   = (state == RESP);
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // fi takes priority over the watchdog when both land in the same WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a   <= '0;
      fpu_b   <= '0;
      fpu_c   <= '0;
      fpu_d   <= '0;
      res_g   <= '0;
      res_err <= 1'b0;
      wd      <= '0;
      job_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job_vld) begin
            fpu_a <= job_a;
            fpu_b <= job_b;
            fpu_c <= job_c;
            fpu_d <= job_d;
          end
        end
        ISSUE: wd <= '0;
        WAIT: begin
          wd <= wd + 1'b1;
          if (fpu_fi) begin
            res_g   <= fpu_g;
            res_err <= 1'b0;
          end else if (wd_expired) begin
            res_g   <= '0;
            res_err <= 1'b1;
          end
        end
        RESP: if (res_rdy) job_cnt <= job_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
